// File: rtl/pipeline_run_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module   : pipeline_ctrl_pkg
// Brief    : Shared state encodings, host opcodes and default widths for the
//            pipeline run-control block.
// Revision : 1.0 - initial release
//==============================================================================
package pipeline_ctrl_pkg;

    localparam int PC_W_DEF  = 9;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } run_state_e;

    localparam logic [1:0] OP_LOAD_PC = 2'd0;
    localparam logic [1:0] OP_RUN     = 2'd1;
    localparam logic [1:0] OP_STEP    = 2'd2;
    localparam logic [1:0] OP_HALT    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pipeline_run_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : pipeline_run_ctrl_if
// Brief    : Host command, datapath status and control bundle for
//            pipeline_run_ctrl. master = host/datapath side, slave = controller.
// Revision : 1.0 - initial release
//==============================================================================
interface pipeline_run_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [PC_W-1:0]  cmd_pc;
    logic [PC_W-1:0]  pc;
    logic             wb_valid;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic             pipe_en;
    logic             flush;
    logic             pc_load;
    logic [PC_W-1:0]  pc_load_val;
    logic [2:0]       state;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_pc, pc, wb_valid, bp_en, bp_addr,
        input  cmd_ready, pipe_en, flush, pc_load, pc_load_val, state,
               halted, bp_hit, cycle_cnt, retire_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_pc, pc, wb_valid, bp_en, bp_addr,
        output cmd_ready, pipe_en, flush, pc_load, pc_load_val, state,
               halted, bp_hit, cycle_cnt, retire_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_run_ctrl_counters.sv
`default_nettype none
//==============================================================================
// Module   : run_ctrl_counters
// Brief    : Free-wrapping cycle and retire counters; clear beats increment.
// Revision : 1.0 - initial release
//==============================================================================
module run_ctrl_counters
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc_cycle,
    input  wire logic             i_inc_retire,
    output logic      [CNT_W-1:0] o_cycle_cnt,
    output logic      [CNT_W-1:0] o_retire_cnt
);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else if (i_clr) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (i_inc_cycle)  r_cycle_cnt  <= r_cycle_cnt + c_ONE;
            if (i_inc_retire) r_retire_cnt <= r_retire_cnt + c_ONE;
        end
    end

    assign o_cycle_cnt  = r_cycle_cnt;
    assign o_retire_cnt = r_retire_cnt;
endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : pipeline_run_ctrl
// Brief    : Host run-control sequencer (load PC / run / step / halt with
//            drain) for the 5-stage pipeline. Optional PC breakpoint enabled
//            by defining RUN_CTRL_BREAKPOINT_EN.
// Revision : 1.0 - initial release
//==============================================================================
module pipeline_run_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int PIPE_DEPTH = 5,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipeline_run_ctrl_if.slave bus
);
    localparam int              c_DW         = $clog2(PIPE_DEPTH);
    localparam logic [c_DW-1:0] c_DRAIN_INIT = c_DW'(PIPE_DEPTH - 1);
    localparam logic [c_DW-1:0] c_DRAIN_ONE  = c_DW'(1);

    run_state_e      r_state,     w_state_nxt;
    logic [c_DW-1:0] r_drain_cnt, w_drain_nxt;
    logic            r_pipe_en,   w_pipe_en_nxt;
    logic            r_flush,     w_flush_nxt;
    logic            r_pc_load,   w_pc_load_nxt;
    logic [PC_W-1:0] r_pc_load_val, w_pc_load_val_nxt;
    logic            r_bp_hit,    w_bp_hit_nxt;
    logic            r_halted,    w_halted_nxt;
    logic            r_cmd_ready, w_cmd_ready_nxt;
    logic            w_clr_cnt;
    logic            w_accept;
    logic            w_bp_match;

    assign w_accept = bus.cmd_valid & r_cmd_ready;

`ifdef RUN_CTRL_BREAKPOINT_EN
    assign w_bp_match = bus.bp_en && (bus.pc == bus.bp_addr);
`else
    logic w_unused_bp;
    assign w_bp_match  = 1'b0;
    assign w_unused_bp = ^{bus.bp_en, bus.bp_addr, bus.pc};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_drain_cnt   <= '0;
            r_pipe_en     <= 1'b0;
            r_flush       <= 1'b0;
            r_pc_load     <= 1'b0;
            r_pc_load_val <= '0;
            r_bp_hit      <= 1'b0;
            r_halted      <= 1'b1;
            r_cmd_ready   <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_drain_cnt   <= w_drain_nxt;
            r_pipe_en     <= w_pipe_en_nxt;
            r_flush       <= w_flush_nxt;
            r_pc_load     <= w_pc_load_nxt;
            r_pc_load_val <= w_pc_load_val_nxt;
            r_bp_hit      <= w_bp_hit_nxt;
            r_halted      <= w_halted_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_drain_nxt       = r_drain_cnt;
        w_pc_load_nxt     = 1'b0;
        w_pc_load_val_nxt = r_pc_load_val;
        w_bp_hit_nxt      = r_bp_hit;
        w_clr_cnt         = 1'b0;

        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (w_accept) begin
                    case (bus.cmd_op)
                        OP_LOAD_PC: begin
                            w_pc_load_nxt     = 1'b1;
                            w_pc_load_val_nxt = bus.cmd_pc;
                            w_clr_cnt         = 1'b1;
                        end
                        OP_RUN: begin
                            w_state_nxt  = ST_RUN;
                            w_bp_hit_nxt = 1'b0;
                        end
                        OP_STEP: begin
                            w_state_nxt  = ST_STEP;
                            w_bp_hit_nxt = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // The breakpointed instruction is fetched this cycle, so it drains like a HALT.
                if (w_bp_match || (w_accept && (bus.cmd_op == OP_HALT))) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = c_DRAIN_INIT;
                end
                if (w_bp_match) w_bp_hit_nxt = 1'b1;
            end
            ST_STEP: begin
                w_state_nxt = ST_DRAIN;
                w_drain_nxt = c_DRAIN_INIT;
                if (w_bp_match) w_bp_hit_nxt = 1'b1;
            end
            ST_DRAIN: begin
                w_drain_nxt = r_drain_cnt - c_DRAIN_ONE;
                if (r_drain_cnt == c_DRAIN_ONE) w_state_nxt = ST_HALTED;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_pipe_en_nxt   = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP) ||
                          (w_state_nxt == ST_DRAIN);
        w_flush_nxt     = (w_state_nxt == ST_DRAIN);
        w_halted_nxt    = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HALTED);
        w_cmd_ready_nxt = w_halted_nxt || (w_state_nxt == ST_RUN);
    end

    run_ctrl_counters #(
        .CNT_W (CNT_W)
    ) u_counters (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr_cnt),
        .i_inc_cycle  (r_pipe_en),
        .i_inc_retire (r_pipe_en & bus.wb_valid),
        .o_cycle_cnt  (bus.cycle_cnt),
        .o_retire_cnt (bus.retire_cnt)
    );

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.pipe_en     = r_pipe_en;
    assign bus.flush       = r_flush;
    assign bus.pc_load     = r_pc_load;
    assign bus.pc_load_val = r_pc_load_val;
    assign bus.state       = r_state;
    assign bus.halted      = r_halted;
    assign bus.bp_hit      = r_bp_hit;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_pipeline_run_ctrl
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            random stimulus against a cycle-level behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pipeline_run_ctrl;
    localparam int PC_W  = 9;
    localparam int CNT_W = 32;
    localparam int DEPTH = 5;
`ifdef RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif
    localparam logic [1:0] LD = 2'd0, RN = 2'd1, SP = 2'd2, HT = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    pipeline_run_ctrl #(.PC_W(PC_W), .PIPE_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // behavioural model: mode uses the externally visible state numbers
    int               m_mode;
    int               m_left;
    bit               m_bp;
    bit               m_pcl;
    logic [PC_W-1:0]  m_pcv;
    logic [CNT_W-1:0] m_cyc;
    logic [CNT_W-1:0] m_ret;
    bit               auto_pc = 1'b0;

    function automatic bit runs_f(input int md);
        return (md >= 1) && (md <= 3);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_bp = 1'b0; m_pcl = 1'b0;
        m_pcv = '0; m_cyc = '0; m_ret = '0;
    endtask

    task automatic model_step();
        int md;
        bit acc, hit, load;
        md   = m_mode;
        acc  = bus.cmd_valid && (md != 2) && (md != 3);
        hit  = BP_ON && bus.bp_en && (bus.pc == bus.bp_addr);
        load = ((md == 0) || (md == 4)) && acc && (bus.cmd_op == LD);
        if (load) begin
            m_cyc = '0; m_ret = '0;
        end else if (runs_f(md)) begin
            m_cyc = m_cyc + 32'd1;
            if (bus.wb_valid) m_ret = m_ret + 32'd1;
        end
        m_pcl = load;
        if (load) m_pcv = bus.cmd_pc;
        case (md)
            0, 4: begin
                if (acc && bus.cmd_op == RN) begin m_mode = 1; m_bp = 1'b0; end
                else if (acc && bus.cmd_op == SP) begin m_mode = 2; m_bp = 1'b0; end
            end
            1: if (hit || (acc && bus.cmd_op == HT)) begin
                   m_mode = 3; m_left = DEPTH - 1;
                   if (hit) m_bp = 1'b1;
               end
            2: begin
                m_mode = 3; m_left = DEPTH - 1;
                if (hit) m_bp = 1'b1;
            end
            default: begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 4;
            end
        endcase
    endtask

    task automatic check_all();
        chk("state",       64'(bus.state),       64'(m_mode));
        chk("pipe_en",     64'(bus.pipe_en),     64'(runs_f(m_mode)));
        chk("flush",       64'(bus.flush),       64'(m_mode == 3));
        chk("halted",      64'(bus.halted),      64'((m_mode == 0) || (m_mode == 4)));
        chk("cmd_ready",   64'(bus.cmd_ready),   64'((m_mode != 2) && (m_mode != 3)));
        chk("pc_load",     64'(bus.pc_load),     64'(m_pcl));
        chk("pc_load_val", 64'(bus.pc_load_val), 64'(m_pcv));
        chk("bp_hit",      64'(bus.bp_hit),      64'(m_bp));
        chk("cycle_cnt",   64'(bus.cycle_cnt),   64'(m_cyc));
        chk("retire_cnt",  64'(bus.retire_cnt),  64'(m_ret));
    endtask

    // one clock: model follows the edge, outputs checked 1 time unit later
    task automatic tick();
        bit pe, fl, pl;
        logic [PC_W-1:0] pv;
        pe = runs_f(m_mode); fl = (m_mode == 3); pl = m_pcl; pv = m_pcv;
        @(posedge clk);
        model_step();
        #1;
        if (auto_pc) begin
            if (pl) bus.pc = pv;
            else if (pe && !fl) bus.pc = bus.pc + 9'd1;
        end
        check_all();
    endtask

    task automatic send(input logic [1:0] op, input logic [PC_W-1:0] p);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_pc = p;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // ticks until HALTED (bounded); returns number of drain cycles seen
    task automatic wait_halt(output int n);
        bit done;
        n = 0; done = 1'b0;
        for (int g = 0; g < 30; g++) begin
            if (!done) begin
                if (bus.state == 3'd4) done = 1'b1;
                else begin
                    if (bus.pipe_en && bus.flush && !bus.cmd_ready) n++;
                    tick();
                end
            end
        end
        chk("wait_halt_timeout", 64'(bus.state), 64'd4);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #2;
        model_reset();
        chk("rst_state",   64'(bus.state),     64'd0);
        chk("rst_pipe_en", 64'(bus.pipe_en),   64'd0);
        chk("rst_cycle",   64'(bus.cycle_cnt), 64'd0);
        chk("rst_halted",  64'(bus.halted),    64'd1);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit          vld;
        logic [1:0]  op;
        logic [8:0]  cpc;
        bit          wb;
        logic [2:0]  st;
        bit          pe, fl, rdy, pcl;
        logic [8:0]  pcv;
        logic [31:0] cyc, ret;
    } vec_t;

    vec_t tbl[16];
    int   n;

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = LD; bus.cmd_pc = '0;
        bus.pc = 9'h1FF; bus.wb_valid = 1'b0; bus.bp_en = 1'b0; bus.bp_addr = '0;
        model_reset();

        //             vld op  cpc     wb  st  pe fl rdy pcl pcv     cyc ret
        tbl[0]  = '{1, LD, 9'h010, 0, 0, 0, 0, 1, 1, 9'h010, 0,  0};
        tbl[1]  = '{0, LD, 9'h000, 0, 0, 0, 0, 1, 0, 9'h010, 0,  0};
        tbl[2]  = '{1, SP, 9'h000, 0, 2, 1, 0, 0, 0, 9'h010, 0,  0};
        tbl[3]  = '{0, LD, 9'h000, 0, 3, 1, 1, 0, 0, 9'h010, 1,  0};
        tbl[4]  = '{1, HT, 9'h000, 1, 3, 1, 1, 0, 0, 9'h010, 2,  1};
        tbl[5]  = '{0, LD, 9'h000, 0, 3, 1, 1, 0, 0, 9'h010, 3,  1};
        tbl[6]  = '{0, LD, 9'h000, 0, 3, 1, 1, 0, 0, 9'h010, 4,  1};
        tbl[7]  = '{0, LD, 9'h000, 0, 4, 0, 0, 1, 0, 9'h010, 5,  1};
        tbl[8]  = '{1, HT, 9'h000, 0, 4, 0, 0, 1, 0, 9'h010, 5,  1};
        tbl[9]  = '{1, RN, 9'h000, 0, 1, 1, 0, 1, 0, 9'h010, 5,  1};
        tbl[10] = '{1, LD, 9'h055, 0, 1, 1, 0, 1, 0, 9'h010, 6,  1};
        tbl[11] = '{1, HT, 9'h000, 0, 3, 1, 1, 0, 0, 9'h010, 7,  1};
        tbl[12] = '{0, LD, 9'h000, 0, 3, 1, 1, 0, 0, 9'h010, 8,  1};
        tbl[13] = '{0, LD, 9'h000, 0, 3, 1, 1, 0, 0, 9'h010, 9,  1};
        tbl[14] = '{0, LD, 9'h000, 0, 3, 1, 1, 0, 0, 9'h010, 10, 1};
        tbl[15] = '{0, LD, 9'h000, 0, 4, 0, 0, 1, 0, 9'h010, 11, 1};

        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_halted", 64'(bus.halted), 64'd1);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            bus.cmd_valid = tbl[i].vld; bus.cmd_op = tbl[i].op;
            bus.cmd_pc = tbl[i].cpc; bus.wb_valid = tbl[i].wb;
            tick();
            chk($sformatf("v%0d.state", i), 64'(bus.state),       64'(tbl[i].st));
            chk($sformatf("v%0d.pe", i),    64'(bus.pipe_en),     64'(tbl[i].pe));
            chk($sformatf("v%0d.fl", i),    64'(bus.flush),       64'(tbl[i].fl));
            chk($sformatf("v%0d.rdy", i),   64'(bus.cmd_ready),   64'(tbl[i].rdy));
            chk($sformatf("v%0d.pcl", i),   64'(bus.pc_load),     64'(tbl[i].pcl));
            chk($sformatf("v%0d.pcv", i),   64'(bus.pc_load_val), 64'(tbl[i].pcv));
            chk($sformatf("v%0d.cyc", i),   64'(bus.cycle_cnt),   64'(tbl[i].cyc));
            chk($sformatf("v%0d.ret", i),   64'(bus.retire_cnt),  64'(tbl[i].ret));
        end
        bus.cmd_valid = 1'b0; bus.wb_valid = 1'b0;

        // RUN for 20 cycles (HALT in the 20th), then 4 drain cycles
        send(LD, 9'h000);
        send(RN, 9'h000);
        repeat (19) tick();
        send(HT, 9'h000);
        wait_halt(n);
        chk("run20_drain_cycles", 64'(n), 64'd4);
        chk("run20_cycle_cnt", 64'(bus.cycle_cnt), 64'd24);

        // STEP from HALTED with one retire during drain
        send(SP, 9'h000);
        tick();
        bus.wb_valid = 1'b1;
        tick();
        bus.wb_valid = 1'b0;
        wait_halt(n);
        chk("step_drain_cycles", 64'(n), 64'd3);
        chk("step_cycle_cnt", 64'(bus.cycle_cnt), 64'd29);
        chk("step_retire_cnt", 64'(bus.retire_cnt), 64'd1);

        // breakpoint at 0x005 while running from PC 0
        auto_pc = 1'b1; bus.pc = 9'h000;
        bus.bp_en = 1'b1; bus.bp_addr = 9'h005;
        send(LD, 9'h000);
        send(RN, 9'h000);
        for (int g = 0; g < 40; g++) if (bus.state != 3'd4) tick();
        if (BP_ON) begin
            chk("bp_state", 64'(bus.state), 64'd4);
            chk("bp_hit", 64'(bus.bp_hit), 64'd1);
            chk("bp_pc_after", 64'(bus.pc), 64'h006);
            send(RN, 9'h000);
            chk("bp_cleared", 64'(bus.bp_hit), 64'd0);
        end else begin
            chk("nobp_state", 64'(bus.state), 64'd1);
            chk("nobp_hit", 64'(bus.bp_hit), 64'd0);
        end
        bus.bp_en = 1'b0;
        send(HT, 9'h000);
        wait_halt(n);
        auto_pc = 1'b0;

        // HALT in the same cycle as a breakpoint hit
        bus.pc = 9'h033; bus.bp_addr = 9'h033;
        send(RN, 9'h000);
        tick();
        bus.bp_en = 1'b1;
        send(HT, 9'h000);
        bus.bp_en = 1'b0;
        wait_halt(n);
        chk("halt_bp_drain_cycles", 64'(n), 64'd4);
        chk("halt_bp_hit", 64'(bus.bp_hit), 64'(BP_ON));

        // reset mid-RUN
        send(RN, 9'h000);
        repeat ($urandom_range(1, 10)) tick();
        async_reset();

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_op    = 2'($urandom_range(0, 3));
            bus.cmd_pc    = 9'($urandom);
            bus.wb_valid  = 1'($urandom_range(0, 1));
            bus.bp_en     = ($urandom_range(0, 3) == 0);
            bus.bp_addr   = 9'($urandom_range(0, 7));
            bus.pc        = 9'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) async_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
